// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit and memory.
//   master (lsu side): drives mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//                      mem_wstrb_o; receives mem_gnt_i, mem_rvalid_i, mem_rdata_i.
//   slave  (memory side): the mirror image.
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wstrb_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit. Accepts one memory request per instruction from ex, runs a
// request/grant/response handshake on the data bus, aligns and extends load
// data and writes it back to the register file. Holds the pipeline while an
// access is outstanding.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_*_i           request from ex (valid, we, func3, addr, wdata, rd)
//   bus               lsu_if.master data-bus handshake
//   rd_addr_o/rd_data_o/rd_wen_o   register-file writeback
//   hold_flag_o       pipeline stall to ctrl
//   misalign_o        one-cycle pulse: misaligned request dropped
//   bus_err_o         one-cycle pulse: access timed out
//
// state | meaning
// IDLE  | no access outstanding; accept a new request
// REQ   | bus request asserted, waiting for grant
// WAIT  | load granted, waiting for read data
// RESP  | load data registered, writeback this cycle
module lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_func3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_addr_i,
  lsu_if.master       bus,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        hold_flag_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              latch, capture, mis_set, err_set;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rd_data_q;
  logic              misalign_q, bus_err_q;

  logic              f3_legal, addr_ok, req_ok, req_misalign;
  logic              cnt_last;
  logic              in_req;
  logic [31:0]       st_data;
  logic [3:0]        st_strb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // request classification from ex
  always_comb begin
    if (req_we_i) f3_legal = (req_func3_i <= 3'd2);
    else          f3_legal = (req_func3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (req_func3_i[1:0])
      2'd1:    addr_ok = ~req_addr_i[0];
      2'd2:    addr_ok = (req_addr_i[1:0] == 2'b00);
      default: addr_ok = 1'b1;
    endcase
  end

  assign req_ok       = req_valid_i & f3_legal & addr_ok;
  assign req_misalign = req_valid_i & f3_legal & ~addr_ok;
  assign cnt_last     = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // grant / rvalid take priority over the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    capture = 1'b0;
    mis_set = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        mis_set = req_misalign;
        if (req_ok) begin
          state_d = REQ;
          cnt_d   = '0;
          latch   = 1'b1;
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          state_d = we_q ? IDLE : WAIT;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          state_d = RESP;
          cnt_d   = '0;
          capture = 1'b1;
        end else if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rd_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= mis_set;
      bus_err_q  <= err_set;
      if (latch) begin
        addr_q  <= req_addr_i[ADDR_W-1:0];
        we_q    <= req_we_i;
        f3_q    <= req_func3_i;
        wdata_q <= req_wdata_i;
        rd_q    <= req_rd_addr_i;
      end
      if (capture) rd_data_q <= ld_data;
    end
  end

  // store lane replication and strobes
  always_comb begin
    case (f3_q[1:0])
      2'd0: begin
        st_data = {4{wdata_q[7:0]}};
        st_strb = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        st_data = {2{wdata_q[15:0]}};
        st_strb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_data = wdata_q;
        st_strb = 4'b1111;
      end
    endcase
  end

  // load extraction
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = bus.mem_rdata_i[7:0];
      2'd1:    ld_byte = bus.mem_rdata_i[15:8];
      2'd2:    ld_byte = bus.mem_rdata_i[23:16];
      default: ld_byte = bus.mem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    case (f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'b0, ld_byte};
      3'd5:    ld_data = {16'b0, ld_half};
      default: ld_data = bus.mem_rdata_i;
    endcase
  end

  // bus outputs are only driven while requesting so they read 0 when idle
  assign in_req          = (state_q == REQ);
  assign bus.mem_req_o   = in_req;
  assign bus.mem_we_o    = in_req & we_q;
  assign bus.mem_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata_o = in_req ? st_data : '0;
  assign bus.mem_wstrb_o = in_req ? st_strb : '0;

  assign rd_addr_o   = rd_q;
  assign rd_data_o   = rd_data_q;
  assign rd_wen_o    = (state_q == RESP) & (rd_q != 5'd0);
  assign hold_flag_o = (state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & req_ok);
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;
endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    bit          skip;
    bit          chk_all;
    bit          mem_req;
    bit          mem_we;
    bit          chk_wdata;
    bit          hold;
    bit          misalign;
    bit          bus_err;
    bit          rd_wen;
    bit          chk_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } exp_t;

  logic        clk, rst;
  logic        req_valid, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wen, hold_flag, misalign, bus_err;

  lsu_if #(.ADDR_W(32)) bus ();

  lsu #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_we_i      (req_we),
    .req_func3_i   (req_func3),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_rd_addr_i (req_rd),
    .bus           (bus),
    .rd_addr_o     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_wen_o      (rd_wen),
    .hold_flag_o   (hold_flag),
    .misalign_o    (misalign),
    .bus_err_o     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  logic [31:0] mem [int unsigned];
  bit pend_mis = 0;
  bit pend_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int unsigned sz(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit we, input logic [2:0] f3);
    if (we) return (f3 <= 3'd2);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic bit aligned(input logic [31:0] a, input logic [2:0] f3);
    return (a % sz(f3)) == 0;
  endfunction

  function automatic logic [3:0] strb(input logic [31:0] a, input logic [2:0] f3);
    int lo;
    int n;
    logic [3:0] s;
    lo = int'(a % 4);
    n  = int'(sz(f3));
    s  = '0;
    for (int i = 0; i < 4; i++) if (i >= lo && i < lo + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] o;
    int n;
    n = int'(sz(f3));
    for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    if (sz(f3) == 1) begin
      v = v & 32'hFF;
      if (f3 < 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz(f3) == 2) begin
      v = v & 32'hFFFF;
      if (f3 < 3'd4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w, l;
    logic [3:0] s;
    w = read_word(a);
    s = strb(a, f3);
    l = lanes(d, f3);
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = l[8*i +: 8];
    mem[a >> 2] = w;
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!e.skip) begin
          chk("mem_req", 32'(bus.mem_req_o), 32'(e.mem_req));
          chk("hold_flag", 32'(hold_flag), 32'(e.hold));
          chk("misalign", 32'(misalign), 32'(e.misalign));
          chk("bus_err", 32'(bus_err), 32'(e.bus_err));
          chk("rd_wen", 32'(rd_wen), 32'(e.rd_wen));
          if (e.mem_req) begin
            chk("mem_we", 32'(bus.mem_we_o), 32'(e.mem_we));
            chk("mem_addr", bus.mem_addr_o, e.addr);
            if (e.chk_wdata) begin
              chk("mem_wdata", bus.mem_wdata_o, e.wdata);
              chk("mem_wstrb", 32'(bus.mem_wstrb_o), 32'(e.wstrb));
            end
          end
          if (e.chk_rd) begin
            chk("rd_addr", 32'(rd_addr), 32'(e.rd_addr));
            chk("rd_data", rd_data, e.rd_data);
          end
          if (e.chk_all) begin
            chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
            chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
            chk("rst_mem_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
            chk("rst_rd_addr", 32'(rd_addr), 32'd0);
            chk("rst_rd_data", rd_data, 32'd0);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input exp_t e);
    e.misalign = pend_mis;
    e.bus_err  = pend_err;
    pend_mis   = 0;
    pend_err   = 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic stray();
    bus.mem_gnt_i    = 1'($urandom % 2);
    bus.mem_rvalid_i = 1'($urandom % 2);
    bus.mem_rdata_i  = $urandom;
  endtask

  task automatic noise();
    req_valid = 1'($urandom % 2);
    req_we    = 1'($urandom % 2);
    req_func3 = 3'($urandom % 8);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_rd    = 5'($urandom % 32);
  endtask

  task automatic idle(input bit late_rvalid);
    exp_t e;
    req_valid = 1'b0;
    stray();
    if (late_rvalid) bus.mem_rvalid_i = 1'b1;
    e = '0;
    tick(e);
  endtask

  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int g, input int r, input bit rst_wait);
    exp_t e;
    bit done;
    logic [31:0] word;
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    stray();
    e = '0;
    if (!legal(we, f3)) begin
      tick(e);
      return;
    end
    if (!aligned(addr, f3)) begin
      tick(e);
      pend_mis = 1;
      return;
    end
    e.hold = 1;
    tick(e);
    done = 0;
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      noise();
      bus.mem_gnt_i    = (k == g);
      bus.mem_rvalid_i = (k == g) && !we && ($urandom % 4 == 0);
      bus.mem_rdata_i  = $urandom;
      e = '0;
      e.mem_req   = 1;
      e.hold      = 1;
      e.mem_we    = we;
      e.addr      = addr & 32'hFFFF_FFFC;
      e.chk_wdata = we;
      e.wdata     = lanes(wdata, f3);
      e.wstrb     = strb(addr, f3);
      tick(e);
      if (k == g) done = 1;
    end
    if (!done) begin
      pend_err = 1;
      return;
    end
    if (we) begin
      mem_write(addr, f3, wdata);
      return;
    end
    done = 0;
    word = read_word(addr);
    for (int k = 0; k < TIMEOUT && !done; k++) begin
      noise();
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = (k == r);
      bus.mem_rdata_i  = (k == r) ? word : $urandom;
      e = '0;
      e.hold = 1;
      if (rst_wait && k == 1) begin
        rst = 1'b1;
        tick(e);
        rst       = 1'b0;
        req_valid = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        e = '0;
        e.chk_all = 1;
        tick(e);
        return;
      end
      tick(e);
      if (k == r) done = 1;
    end
    if (!done) begin
      pend_err = 1;
      return;
    end
    noise();
    stray();
    e = '0;
    e.rd_wen  = (rd != 5'd0);
    e.chk_rd  = 1;
    e.rd_addr = rd;
    e.rd_data = ld_val(word, addr, f3);
    tick(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int g, r;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    @(posedge clk);
    #1;

    // model pins (hand-computed)
    chk("pin_lb_100",  ld_val(32'h8000_FF7F, 32'h100, 3'd0), 32'h0000_007F);
    chk("pin_lb_101",  ld_val(32'h8000_FF7F, 32'h101, 3'd0), 32'hFFFF_FFFF);
    chk("pin_lhu_102", ld_val(32'h8000_FF7F, 32'h102, 3'd5), 32'h0000_8000);
    chk("pin_lh_102",  ld_val(32'h8000_FF7F, 32'h102, 3'd1), 32'hFFFF_8000);
    chk("pin_sb_strb", 32'(strb(32'h203, 3'd0)), 32'h8);
    chk("pin_sb_data", lanes(32'h1234_56AB, 3'd0), 32'hABAB_ABAB);
    chk("pin_sh_strb", 32'(strb(32'h202, 3'd1)), 32'hC);
    chk("pin_sw_strb", 32'(strb(32'h200, 3'd2)), 32'hF);
    chk("pin_lw_mis",  32'(aligned(32'h102, 3'd2)), 32'd0);
    chk("pin_sh_mis",  32'(aligned(32'h201, 3'd1)), 32'd0);

    e = '0; e.skip = 1;
    tick(e);
    tick(e);
    rst = 1'b0;
    e = '0; e.chk_all = 1;
    tick(e);

    // loads from a known word, zero-wait bus
    mem[32'h40] = 32'h8000_FF7F;
    access(0, 3'd0, 32'h100, 32'h0, 5'd1, 0, 0, 0);
    access(0, 3'd0, 32'h101, 32'h0, 5'd2, 0, 0, 0);
    access(0, 3'd5, 32'h102, 32'h0, 5'd3, 0, 0, 0);
    access(0, 3'd1, 32'h102, 32'h0, 5'd4, 0, 0, 0);
    idle(0);
    // stores
    access(1, 3'd0, 32'h203, 32'h1234_56AB, 5'd0, 0, 0, 0);
    access(1, 3'd1, 32'h202, 32'h1234_56AB, 5'd0, 0, 0, 0);
    access(1, 3'd2, 32'h200, 32'h1234_56AB, 5'd0, 0, 0, 0);
    access(0, 3'd2, 32'h200, 32'h0, 5'd5, 0, 0, 0);
    // misaligned
    access(0, 3'd2, 32'h102, 32'h0, 5'd6, 0, 0, 0);
    idle(0);
    access(1, 3'd1, 32'h201, 32'h0, 5'd0, 0, 0, 0);
    idle(0);
    // delayed grant and rvalid
    access(0, 3'd2, 32'h104, 32'h0, 5'd7, 5, 3, 0);
    idle(0);
    // timeout with no grant, then a late rvalid
    access(0, 3'd2, 32'h108, 32'h0, 5'd8, 20, 0, 0);
    idle(1);
    idle(1);
    // timeout in WAIT
    access(0, 3'd2, 32'h10C, 32'h0, 5'd9, 1, 20, 0);
    idle(0);
    // reset while waiting, then a load to x0
    access(0, 3'd2, 32'h110, 32'h0, 5'd10, 0, 5, 1);
    access(0, 3'd2, 32'h100, 32'h0, 5'd0, 0, 0, 0);
    idle(0);

    repeat (250) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) idle(0);
      g = ($urandom % 16 == 0) ? 9 : int'($urandom_range(0, 3));
      r = ($urandom % 16 == 0) ? 9 : int'($urandom_range(0, 3));
      access(1'($urandom % 2), 3'($urandom % 8), 32'h100 + $urandom_range(0, 63),
             $urandom, 5'($urandom % 32), g, r, 0);
    end
    idle(0);
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
